// File: rtl/beamsum_uart_tx.sv
// Captures every other beamformer sum while sumflag is high, then sends each sample as five 8N1 bytes, least-significant byte first.
// Define BEAMSUM_UART_HEADER_EN to send a 4-byte header (A5 5A count_lo count_hi) before the first sample.
module beamsum_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 540,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [39:0]       summed_value,
  input  logic              sumflag,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   sample_count
);

`ifdef BEAMSUM_UART_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  localparam logic [15:0]     BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP, S_FINISH
  } state_t;

  state_t              state_reg, state_next;
  logic                phase_reg, phase_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
  logic [39:0]         word_reg, word_next;
  logic [2:0]          byte_idx_reg, byte_idx_next;
  logic [2:0]          bit_idx_reg, bit_idx_next;
  logic [15:0]         clk_cnt_reg, clk_cnt_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                overflow_reg, overflow_next;
  logic                hdr_reg, hdr_next;

  logic                we;
  logic [39:0]         rd_data;
  logic [39:0]         mem [DEPTH];
  logic                bit_end;
  logic [2:0]          last_byte;
  logic [15:0]         cnt16;
  logic [39:0]         hdr_word;
  logic [7:0]          cur_byte;

  assign bit_end   = (clk_cnt_reg == BIT_LAST);
  assign last_byte = hdr_reg ? 3'd3 : 3'd4;
  assign cnt16     = 16'(count_reg);
  assign hdr_word  = {8'h00, cnt16[15:8], cnt16[7:0], 8'h5A, 8'hA5};
  assign cur_byte  = word_reg[{byte_idx_reg, 3'b000} +: 8];

  // Sample buffer: write port driven by capture, registered read for FETCH/LOAD.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[count_reg[ADDR_W-1:0]] <= summed_value;
    end
    rd_data <= mem[rd_addr_reg];
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    count_next    = count_reg;
    rd_addr_next  = rd_addr_reg;
    word_next     = word_reg;
    byte_idx_next = byte_idx_reg;
    bit_idx_next  = bit_idx_reg;
    clk_cnt_next  = clk_cnt_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    overflow_next = overflow_reg;
    hdr_next      = hdr_reg;
    we            = 1'b0;

    if (sumflag && state_reg != S_IDLE && state_reg != S_CAPTURE) begin
      overflow_next = 1'b1;
    end

    unique case (state_reg)
      S_IDLE: begin
        if (sumflag) begin
          // This cycle is phase 0, so the next CAPTURE cycle is phase 1.
          state_next   = S_CAPTURE;
          count_next   = '0;
          done_next    = 1'b0;
          phase_next   = 1'b1;
          busy_next    = 1'b1;
          rd_addr_next = '0;
          hdr_next     = HDR_EN;
        end
      end
      S_CAPTURE: begin
        phase_next = ~phase_reg;
        if (!sumflag) begin
          if (count_reg != '0) begin
            state_next = S_FETCH;
          end else begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
          end
        end else if (phase_reg) begin
          if (count_reg < DEPTH_C) begin
            we         = 1'b1;
            count_next = count_reg + 1'b1;
          end else begin
            overflow_next = 1'b1;
          end
        end
      end
      S_FETCH: begin
        state_next = S_LOAD;
      end
      S_LOAD: begin
        word_next     = hdr_reg ? hdr_word : rd_data;
        byte_idx_next = '0;
        clk_cnt_next  = '0;
        state_next    = S_START;
      end
      S_START: begin
        clk_cnt_next = clk_cnt_reg + 1'b1;
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = S_DATA;
        end
      end
      S_DATA: begin
        clk_cnt_next = clk_cnt_reg + 1'b1;
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      S_STOP: begin
        clk_cnt_next = clk_cnt_reg + 1'b1;
        if (bit_end) begin
          clk_cnt_next = '0;
          if (byte_idx_reg < last_byte) begin
            byte_idx_next = byte_idx_reg + 1'b1;
            state_next    = S_START;
          end else if (hdr_reg) begin
            // Header done; rd_addr is still 0 so sample 0 is fetched next.
            hdr_next   = 1'b0;
            state_next = S_FETCH;
          end else if (({1'b0, rd_addr_reg} + 1'b1) < count_reg) begin
            rd_addr_next = rd_addr_reg + 1'b1;
            state_next   = S_FETCH;
          end else begin
            state_next = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      phase_reg    <= 1'b0;
      count_reg    <= '0;
      rd_addr_reg  <= '0;
      word_reg     <= '0;
      byte_idx_reg <= '0;
      bit_idx_reg  <= '0;
      clk_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      hdr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      count_reg    <= count_next;
      rd_addr_reg  <= rd_addr_next;
      word_reg     <= word_next;
      byte_idx_reg <= byte_idx_next;
      bit_idx_reg  <= bit_idx_next;
      clk_cnt_reg  <= clk_cnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      overflow_reg <= overflow_next;
      hdr_reg      <= hdr_next;
    end
  end

  // The line is a pure function of registered state, so reset forces it idle on the next edge.
  always_comb begin
    tx = 1'b1;
    if (state_reg == S_START) begin
      tx = 1'b0;
    end else if (state_reg == S_DATA) begin
      tx = cur_byte[bit_idx_reg];
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign overflow     = overflow_reg;
  assign sample_count = count_reg;

endmodule
